commit_trace_buffer: RTL and testbench

Synthesizable on-chip trace recorder for the out-of-order core's result/write buses. It captures up to CHANNELS write-bus events per cycle, time-stamped by an internal cycle counter, into a circular buffer. The buffer runs in wrap (overwrite-oldest) or stop-when-full mode and supports a sticky freeze trigger. Entries are drained oldest-first through a valid/ready read port. It is the hardware successor to the simulation-only cycle counter and bus dump, and sits beside the CPU top on the write buses.

---
 rtl/commit_trace_buffer.sv | 188 ++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : On-chip trace recorder for the core's result/write buses.
//               Each cycle up to CHANNELS bus events are time-stamped with the
//               internal cycle counter and stored, in ascending channel order,
//               into a circular buffer. The buffer either overwrites its
//               oldest entries (wrap, mode=0) or drops new events once full
//               (stop, mode=1). A sticky freeze trigger halts capture. Entries
//               are drained oldest-first through a valid/ready read port.
// Ports       : clk, nrst (async, active low)
//               en, mode, freeze, clear       - capture control
//               wb_valid/wb_iq_pos/wb_addr/wb_data - packed per-channel buses
//               rd_ready, rd_valid, rd_*      - head-entry read port
//               count, drop_count, frozen, cycle - status
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer #(
    parameter int CHANNELS   = 3,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int POS_W      = 3,
    parameter int DEPTH_LOG2 = 4,
    parameter int CYCLE_W    = 16,
    parameter int DROP_W     = 8,
    localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         en,
    input  logic                         mode,
    input  logic                         freeze,
    input  logic                         clear,
    input  logic [CHANNELS-1:0]          wb_valid,
    input  logic [CHANNELS*POS_W-1:0]    wb_iq_pos,
    input  logic [CHANNELS*ADDR_W-1:0]   wb_addr,
    input  logic [CHANNELS*DATA_W-1:0]   wb_data,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [CYCLE_W-1:0]           rd_cycle,
    output logic [CHAN_W-1:0]            rd_chan,
    output logic [POS_W-1:0]             rd_iq_pos,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic [DEPTH_LOG2:0]          count,
    output logic [DROP_W-1:0]            drop_count,
    output logic                         frozen,
    output logic [CYCLE_W-1:0]           cycle
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Arithmetic width able to hold DEPTH + CHANNELS without overflow.
    localparam int CNT_W = DEPTH_LOG2 + 2;
    localparam int SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] c_drop_max = SUM_W'((64'd1 << DROP_W) - 64'd1);

    if ((CHANNELS < 1) || (CHANNELS > DEPTH)) begin : g_bad_channels
        $error("commit_trace_buffer: CHANNELS must be in 1..DEPTH");
    end

    // Storage (no reset: contents are masked while empty)
    logic [CYCLE_W-1:0] r_mem_cycle [DEPTH];
    logic [CHAN_W-1:0]  r_mem_chan  [DEPTH];
    logic [POS_W-1:0]   r_mem_pos   [DEPTH];
    logic [ADDR_W-1:0]  r_mem_addr  [DEPTH];
    logic [DATA_W-1:0]  r_mem_data  [DEPTH];

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DROP_W-1:0]     r_drop;
    logic [CYCLE_W-1:0]    r_cycle;
    logic                  r_frozen;

    logic                  w_pop;
    logic                  w_capture;
    logic [CNT_W-1:0]      w_nvalid;
    logic [CNT_W-1:0]      w_rank [CHANNELS];
    logic [CNT_W-1:0]      w_free;
    logic [CNT_W-1:0]      w_total;
    logic [CNT_W-1:0]      w_accept;
    logic [CNT_W-1:0]      w_evict;
    logic [CNT_W-1:0]      w_lost;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [SUM_W-1:0]      w_drop_sum;
    logic [DROP_W-1:0]     w_drop_next;
    logic                  w_wen   [CHANNELS];
    logic [DEPTH_LOG2-1:0] w_waddr [CHANNELS];

    always_comb begin
        w_pop     = rd_valid && rd_ready && !clear;
        w_capture = en && !r_frozen && !clear;

        // Rank of each valid channel among this cycle's events; it is both the
        // write offset and the acceptance order in stop mode.
        w_nvalid = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_rank[ch] = w_nvalid;
            if (w_capture && wb_valid[ch]) begin
                w_nvalid = w_nvalid + CNT_W'(1);
            end
        end

        w_free  = CNT_W'(DEPTH) - CNT_W'(r_count) + CNT_W'(w_pop);
        w_total = CNT_W'(r_count) - CNT_W'(w_pop) + w_nvalid;
        w_accept = w_nvalid;
        w_evict  = '0;
        w_lost   = '0;
        if (mode) begin
            if (w_nvalid > w_free) begin
                w_accept = w_free;
            end
            w_lost = w_nvalid - w_accept;
        end else begin
            if (w_total > CNT_W'(DEPTH)) begin
                w_evict = w_total - CNT_W'(DEPTH);
            end
            w_lost = w_evict;
        end

        w_count_next = (DEPTH_LOG2 + 1)'(CNT_W'(r_count) - CNT_W'(w_pop) + w_accept - w_evict);

        w_drop_sum = SUM_W'(r_drop) + SUM_W'(w_lost);
        if (w_drop_sum > c_drop_max) begin
            w_drop_next = DROP_W'(c_drop_max);
        end else begin
            w_drop_next = DROP_W'(w_drop_sum);
        end

        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_wen[ch]   = w_capture && wb_valid[ch] && (w_rank[ch] < w_accept);
            w_waddr[ch] = r_wr_ptr + DEPTH_LOG2'(w_rank[ch]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
            r_cycle  <= '0;
            r_frozen <= 1'b0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
            r_cycle  <= '0;
            r_frozen <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(w_accept);
            // Pops and wrap-mode evictions both retire entries at the head.
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(CNT_W'(w_pop) + w_evict);
            r_count  <= w_count_next;
            r_drop   <= w_drop_next;
            r_cycle  <= r_cycle + CYCLE_W'(1);
            if (freeze) begin
                r_frozen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (w_wen[ch]) begin
                r_mem_cycle[w_waddr[ch]] <= r_cycle;
                r_mem_chan[w_waddr[ch]]  <= CHAN_W'(ch);
                r_mem_pos[w_waddr[ch]]   <= wb_iq_pos[ch*POS_W +: POS_W];
                r_mem_addr[w_waddr[ch]]  <= wb_addr[ch*ADDR_W +: ADDR_W];
                r_mem_data[w_waddr[ch]]  <= wb_data[ch*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_valid   = (r_count != '0);
    assign rd_cycle   = rd_valid ? r_mem_cycle[r_rd_ptr] : '0;
    assign rd_chan    = rd_valid ? r_mem_chan[r_rd_ptr]  : '0;
    assign rd_iq_pos  = rd_valid ? r_mem_pos[r_rd_ptr]   : '0;
    assign rd_addr    = rd_valid ? r_mem_addr[r_rd_ptr]  : '0;
    assign rd_data    = rd_valid ? r_mem_data[r_rd_ptr]  : '0;
    assign count      = r_count;
    assign drop_count = r_drop;
    assign frozen     = r_frozen;
    assign cycle      = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Directed self-checking bench for commit_trace_buffer with
//               default parameters (3 channels, depth 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic        mode;
    logic        freeze;
    logic        clear;
    logic [2:0]  wb_valid;
    logic [8:0]  wb_iq_pos;
    logic [14:0] wb_addr;
    logic [95:0] wb_data;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_cycle;
    logic [1:0]  rd_chan;
    logic [2:0]  rd_iq_pos;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic [7:0]  drop_count;
    logic        frozen;
    logic [15:0] cycle;

    int n_cmp  = 0;
    int n_fail = 0;

    commit_trace_buffer dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .mode       (mode),
        .freeze     (freeze),
        .clear      (clear),
        .wb_valid   (wb_valid),
        .wb_iq_pos  (wb_iq_pos),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_cycle   (rd_cycle),
        .rd_chan    (rd_chan),
        .rd_iq_pos  (rd_iq_pos),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .count      (count),
        .drop_count (drop_count),
        .frozen     (frozen),
        .cycle      (cycle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address and IQ position are derived from the data value of each channel.
    task automatic drive(input logic [2:0] v, input int d0, input int d1, input int d2);
        wb_valid  = v;
        wb_data   = {32'(d2), 32'(d1), 32'(d0)};
        wb_addr   = {5'(d2), 5'(d1), 5'(d0)};
        wb_iq_pos = {3'(d2), 3'(d1), 3'(d0)};
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; mode = 1'b0; freeze = 1'b0; clear = 1'b0;
        rd_ready = 1'b0;
        drive(3'b000, 0, 0, 0);
        repeat (2) tick();

        check("reset_count", count, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_cycle", cycle, 0);
        check("reset_drop", drop_count, 0);
        check("reset_frozen", frozen, 0);
        check("reset_rd_data", rd_data, 0);

        // Multi-channel ordering, capture at cycle 7
        nrst = 1'b1;
        en   = 1'b1;
        repeat (7) tick();
        check("cycle_7", cycle, 7);
        drive(3'b101, 3, 0, 9);
        tick();
        drive(3'b000, 0, 0, 0);
        check("ord_count", count, 2);
        check("ord_valid", rd_valid, 1);
        check("ord_cycle0", rd_cycle, 7);
        check("ord_chan0", rd_chan, 0);
        check("ord_addr0", rd_addr, 3);
        check("ord_pos0", rd_iq_pos, 3);
        rd_ready = 1'b1;
        tick();
        check("ord_cycle1", rd_cycle, 7);
        check("ord_chan1", rd_chan, 2);
        check("ord_addr1", rd_addr, 9);
        check("ord_pos1", rd_iq_pos, 1);
        check("ord_data1", rd_data, 9);
        tick();
        rd_ready = 1'b0;
        check("ord_empty", rd_valid, 0);
        check("ord_masked_addr", rd_addr, 0);
        en = 1'b0;
        drive(3'b111, 1, 2, 3);
        tick();
        check("en_off_count", count, 0);
        en = 1'b1;

        // Stop mode, full buffer
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(3'b111, 3*i+1, 3*i+2, 3*i+3);
            tick();
        end
        drive(3'b001, 16, 0, 0);
        tick();
        check("stop_fill_count", count, 16);
        check("stop_fill_drop", drop_count, 0);
        check("stop_head", rd_data, 1);
        rd_ready = 1'b1;
        drive(3'b111, 17, 18, 19);
        tick();
        rd_ready = 1'b0;
        check("stop_pop_count", count, 16);
        check("stop_pop_drop", drop_count, 2);
        check("stop_pop_head", rd_data, 2);
        drive(3'b111, 20, 21, 22);
        tick();
        drive(3'b000, 0, 0, 0);
        check("stop_full_drop", drop_count, 5);
        check("stop_full_count", count, 16);
        rd_ready = 1'b1;
        repeat (15) tick();
        check("stop_last_data", rd_data, 17);
        check("stop_last_count", count, 1);
        tick();
        rd_ready = 1'b0;
        check("stop_drained", count, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_drop", drop_count, 0);
        check("clear_cycle", cycle, 0);

        // Wrap mode overflow
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(3'b111, 3*i+1, 3*i+2, 3*i+3);
            tick();
        end
        check("wrap_fill_count", count, 15);
        drive(3'b111, 16, 17, 18);
        tick();
        check("wrap_ovf_count", count, 16);
        check("wrap_ovf_drop", drop_count, 2);
        check("wrap_ovf_head", rd_data, 3);
        rd_ready = 1'b1;
        drive(3'b111, 19, 20, 21);
        tick();
        rd_ready = 1'b0;
        drive(3'b000, 0, 0, 0);
        check("wrap_pop_count", count, 16);
        check("wrap_pop_drop", drop_count, 4);
        check("wrap_pop_head", rd_data, 6);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear2_count", count, 0);

        // Freeze and clear
        repeat (20) tick();
        check("cycle_20", cycle, 20);
        freeze = 1'b1;
        drive(3'b001, 85, 0, 0);
        tick();
        freeze = 1'b0;
        check("frz_flag", frozen, 1);
        check("frz_count", count, 1);
        check("frz_ts", rd_cycle, 20);
        check("frz_data", rd_data, 85);
        drive(3'b111, 1, 2, 3);
        tick();
        check("frz_ignored", count, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("frz_drain", count, 0);
        check("frz_sticky", frozen, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(3'b000, 0, 0, 0);
        check("clr_frozen", frozen, 0);
        check("clr_count", count, 0);
        check("clr_cycle", cycle, 0);

        // Drop counter saturation in stop mode
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(3'b111, 3*i+1, 3*i+2, 3*i+3);
            tick();
        end
        check("sat_fill_count", count, 16);
        check("sat_fill_drop", drop_count, 2);
        drive(3'b111, 7, 7, 7);
        repeat (100) tick();
        drive(3'b000, 0, 0, 0);
        check("sat_drop", drop_count, 255);
        rd_ready = 1'b1;
        repeat (11) tick();
        rd_ready = 1'b0;
        check("pre_rst_count", count, 5);

        // Asynchronous reset mid-operation
        #2;
        nrst = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", rd_valid, 0);
        check("arst_cycle", cycle, 0);
        check("arst_drop", drop_count, 0);
        check("arst_rd_data", rd_data, 0);
        nrst = 1'b1;

        // Cycle counter wrap-around
        repeat (65535) tick();
        check("cycle_max", cycle, 65535);
        drive(3'b001, 102, 0, 0);
        tick();
        check("cycle_wrapped", cycle, 0);
        drive(3'b001, 119, 0, 0);
        tick();
        drive(3'b000, 0, 0, 0);
        check("wrap_ts_count", count, 2);
        check("ts_max", rd_cycle, 65535);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("ts_zero", rd_cycle, 0);
        check("ts_zero_data", rd_data, 119);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
